// File: rtl/rr_mux_arb.sv
// rtl/rr_mux_arb.sv - N-channel arbitrated mux with a single registered output stage
// Grant policy (round-robin, fixed priority, or direct select) is fixed by MODE at elaboration.
module rr_mux_arb #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int MODE  = 0,
    localparam int SW   = (NCH <= 2) ? 1 : $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SW-1:0]        sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] data_q,  data_d;
    logic [SW-1:0]    ch_q,    ch_d;
    logic             valid_q, valid_d;
    logic [SW-1:0]    ptr_q,   ptr_d;

    logic             load;
    logic [NCH-1:0]   ge_mask;
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   grant_oh;
    logic [SW-1:0]    grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             xfer;

    assign load = !valid_q || out_ready;

    // Request vector per mode; round-robin prefers channels at or above ptr, else wraps.
    always_comb begin
        req     = '0;
        ge_mask = {NCH{1'b1}} << ptr_q;
        if (MODE == 0) begin
            req = ((in_valid & ge_mask) != '0) ? (in_valid & ge_mask) : in_valid;
        end else if (MODE == 1) begin
            req = in_valid;
        end else begin
            // An out-of-range sel shifts the single bit out entirely, granting nothing.
            req = in_valid & ({{(NCH-1){1'b0}}, 1'b1} << sel);
        end
    end

    assign grant_oh = req & (~req + {{(NCH-1){1'b0}}, 1'b1});

    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_oh[i]) begin
                grant_idx  = SW'(i);
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = (load && rst_n) ? grant_oh : '0;
    assign xfer     = (in_ready != '0);

    always_comb begin
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            data_d  = grant_data;
            ch_d    = grant_idx;
            valid_d = 1'b1;
            if (MODE == 0) begin
                ptr_d = (grant_idx == SW'(NCH-1)) ? '0 : grant_idx + SW'(1);
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;

endmodule

// File: doc/rr_mux_arb.md
RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel (>=1).
REQ-002 Parameter NCH, default 4, number of input channels (2..16); SW = max(1, clog2(NCH)).
REQ-003 Parameter MODE, default 0: 0 = round-robin, 1 = fixed priority (channel 0 highest), 2 = direct select via sel.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NCH  channel i has data offered.
REQ-008 in_ready  output  NCH  channel i transfer accepted this cycle.
REQ-009 sel  input  SW  channel index, used only when MODE==2.
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_ch  output  SW  registered index of channel that supplied out_data.
REQ-012 out_valid  output  1  out_data/out_ch hold a valid beat.
REQ-013 out_ready  input  1  downstream accepts beat.

Function
REQ-014 Input transfer on channel i occurs in a cycle where in_valid[i] && in_ready[i]; output transfer occurs where out_valid && out_ready.
REQ-015 load = !out_valid || out_ready; at most one in_ready bit is high, and only when load is high.
REQ-016 in_ready is combinational from in_valid, sel, load and arbiter state; in_ready[i] never depends on in_ready[j] of another channel.
REQ-017 MODE 0: grant goes to the first requesting channel searching ptr, ptr+1, ... NCH-1, 0, ... (wrap-around modulo NCH).
REQ-018 MODE 0: ptr updates to (granted index + 1) mod NCH only on a cycle with an input transfer; otherwise ptr holds.
REQ-019 MODE 1: grant goes to the lowest-index requesting channel; ptr unused and held at 0.
REQ-020 MODE 2: grant goes to channel sel if in_valid[sel]; sel >= NCH grants nothing; other channels are never granted.
REQ-021 On input transfer, out_data <= selected channel data, out_ch <= granted index, out_valid <= 1, all on the next rising edge (latency 1 cycle).
REQ-022 Output transfer without concurrent input transfer: out_valid <= 0; out_data and out_ch hold their last values.
REQ-023 Simultaneous output and input transfer: new beat replaces old in the same edge, out_valid stays 1 (full throughput, one beat per cycle).
REQ-024 out_valid && !out_ready: out_data, out_ch, out_valid, ptr held stable; all in_ready low.
REQ-025 No request in a load cycle: no grant, ptr holds, out_valid follows REQ-022.
REQ-026 No beat is duplicated or dropped; every accepted input appears exactly once on the output in acceptance order.

Reset
REQ-027 While rst_n low: out_valid=0, out_data=0, out_ch=0, ptr=0, in_ready all 0, regardless of clk.
REQ-028 Reset asserted mid-operation discards any held beat immediately (asynchronously); no transfer is reported in that cycle.
REQ-029 After rst_n deasserts, first grant in MODE 0 starts search at channel 0.

Verification (NCH=4, WIDTH=8)
REQ-030 MODE 0, all in_valid=1, data ch i = 8'h10+i, out_ready=1 -> out_ch sequence 0,1,2,3,0,... one beat per cycle, out_data 10,11,12,13,10.
REQ-031 MODE 0, after grant to ch3 only ch0 and ch2 request -> next grant ch0 (wrap), then ch2.
REQ-032 MODE 1, in_valid=4'b1110 -> ch1 granted every cycle, ch2/ch3 starved, out_ch=1.
REQ-033 MODE 2, sel=2, in_valid=4'b1111 -> only in_ready[2] toggles; sel=2 with in_valid[2]=0 -> no grant, out_valid drops after pending beat leaves.
REQ-034 Backpressure: beat 8'hA5 held with out_ready=0 for 5 cycles -> out_data=A5, out_valid=1, in_ready=0 throughout; out_ready=1 -> A5 accepted once, next beat loads same edge.
REQ-035 rst_n pulled low asynchronously between edges while out_valid=1 -> out_valid=0, out_data=0 immediately; after release ch0 wins first.
